// File: rtl/cdb_writeback_arbiter_if.sv
// Requester-side handshake and WP1 broadcast bundle of the CDB writeback arbiter.
// The arbiter uses the slave modport; execution units / benches use master.
`ifndef ROB_SIZE_bits
`define ROB_SIZE_bits 4
`endif

interface cdb_writeback_arbiter_if #(
    parameter int NREQ = 3
);
    localparam int RW = `ROB_SIZE_bits + 1;

    logic                 ROB_FLUSH_Flag;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_wen;
    logic [NREQ*RW-1:0]   req_roben;
    logic [NREQ*5-1:0]    req_dr;
    logic [NREQ*32-1:0]   req_data;

    logic                 WP1_Valid;
    logic                 WP1_Wen;
    logic [RW-1:0]        WP1_ROBEN;
    logic [4:0]           WP1_DRindex;
    logic [31:0]          WP1_Data;
    logic [2:0]           WP1_Grant;

    modport master (
        output ROB_FLUSH_Flag, req_valid, req_wen, req_roben, req_dr, req_data,
        input  req_ready, WP1_Valid, WP1_Wen, WP1_ROBEN, WP1_DRindex, WP1_Data, WP1_Grant
    );

    modport slave (
        input  ROB_FLUSH_Flag, req_valid, req_wen, req_roben, req_dr, req_data,
        output req_ready, WP1_Valid, WP1_Wen, WP1_ROBEN, WP1_DRindex, WP1_Data, WP1_Grant
    );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Round-robin writeback arbiter: NREQ one-entry holding buffers onto the registered WP1 port.
// Define CDB_ARB_FIXED_PRIORITY_EN for fixed priority (index 0 highest) instead of round-robin.
`ifndef ROB_SIZE_bits
`define ROB_SIZE_bits 4
`endif

module cdb_writeback_arbiter #(
    parameter int NREQ = 3
) (
    input  logic clk,
    input  logic rst,
    cdb_writeback_arbiter_if.slave bus
);
    localparam int RW = `ROB_SIZE_bits + 1;

    typedef struct packed {
        logic          wen;
        logic [RW-1:0] roben;
        logic [4:0]    dr;
        logic [31:0]   data;
    } entry_t;

    logic [NREQ-1:0] full;
    entry_t          ent    [NREQ];
    entry_t          in_ent [NREQ];
    logic [NREQ-1:0] accept;
    logic [NREQ-1:0] grant_vec;
    logic            any_grant;
    logic [2:0]      grant_idx;
    entry_t          gnt_ent;
`ifndef CDB_ARB_FIXED_PRIORITY_EN
    logic [2:0]      ptr;
`endif

    // Pick the full buffer closest to the priority origin (ptr, or 0 in fixed mode).
    always_comb begin
        int rel;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        any_grant = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        gnt_ent   = '0;
        rel       = 0;
        for (int d = 0; d < NREQ; d++) begin
            for (int i = 0; i < NREQ; i++) begin
`ifdef CDB_ARB_FIXED_PRIORITY_EN
                rel = i;
`else
                rel = i - int'(ptr);
                if (rel < 0) rel = rel + NREQ;
`endif
                // NOTE: blocking assignments here, since later iterations must see any_grant already set.
                if (!any_grant && full[i] && rel == d) begin
                    any_grant    = 1'b1;
                    grant_idx    = 3'(i);
                    grant_vec[i] = 1'b1;
                    gnt_ent      = ent[i];
                end
            end
        end
    end

    // Ready frees up in the same cycle the buffer is granted; flush blocks all capture.
    always_comb begin
        bus.req_ready = '0;
        accept        = '0;
        for (int i = 0; i < NREQ; i++) begin
            in_ent[i].wen   = bus.req_wen[i];
            in_ent[i].roben = bus.req_roben[i*RW +: RW];
            in_ent[i].dr    = bus.req_dr[i*5 +: 5];
            in_ent[i].data  = bus.req_data[i*32 +: 32];
            bus.req_ready[i] = !bus.ROB_FLUSH_Flag && (!full[i] || grant_vec[i]);
            accept[i]        = bus.req_valid[i] && bus.req_ready[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full            <= '0;
`ifndef CDB_ARB_FIXED_PRIORITY_EN
            ptr             <= '0;
`endif
            bus.WP1_Valid   <= 1'b0;
            bus.WP1_Wen     <= 1'b0;
            bus.WP1_ROBEN   <= '0;
            bus.WP1_DRindex <= '0;
            bus.WP1_Data    <= '0;
            bus.WP1_Grant   <= '0;
        end else if (bus.ROB_FLUSH_Flag) begin
            full          <= '0;
`ifndef CDB_ARB_FIXED_PRIORITY_EN
            ptr           <= '0;
`endif
            bus.WP1_Valid <= 1'b0;
            bus.WP1_Wen   <= 1'b0;
        end else begin
            // A ROB tag of zero is a null result: accepted, but never occupies the buffer.
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i] && in_ent[i].roben != '0) full[i] <= 1'b1;
                else if (grant_vec[i])                  full[i] <= 1'b0;
            end
            if (any_grant) begin
                bus.WP1_Valid   <= 1'b1;
                bus.WP1_Wen     <= gnt_ent.wen && (gnt_ent.dr != 5'd0);
                bus.WP1_ROBEN   <= gnt_ent.roben;
                bus.WP1_DRindex <= gnt_ent.dr;
                bus.WP1_Data    <= gnt_ent.data;
                bus.WP1_Grant   <= grant_idx;
`ifndef CDB_ARB_FIXED_PRIORITY_EN
                ptr <= (grant_idx == 3'(NREQ - 1)) ? 3'd0 : grant_idx + 3'd1;
`endif
            end else begin
                bus.WP1_Valid <= 1'b0;
                bus.WP1_Wen   <= 1'b0;
            end
        end
    end

    // NOTE: payload storage has no reset; its contents are only observed while the matching full bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) ent[i] <= in_ent[i];
        end
    end
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Randomized scoreboard bench for cdb_writeback_arbiter against a per-requester pending-result model.
`ifndef ROB_SIZE_bits
`define ROB_SIZE_bits 4
`endif

module tb_cdb_writeback_arbiter;
    localparam int NREQ = 3;
    localparam int RW   = `ROB_SIZE_bits + 1;

    typedef struct {
        logic          wen;
        logic [RW-1:0] roben;
        logic [4:0]    dr;
        logic [31:0]   data;
    } res_t;

    typedef struct {
        logic          wen;
        logic [RW-1:0] roben;
        logic [4:0]    dr;
        logic [31:0]   data;
        logic [2:0]    grant;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdb_writeback_arbiter_if #(.NREQ(NREQ)) bus ();
    cdb_writeback_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Model: which requesters have a result waiting, what it is, and the priority origin.
    bit   pend   [NREQ];
    res_t pend_e [NREQ];
    int   rr = 0;
    res_t in_e   [NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (bus.WP1_Valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("wp1_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("wp1_wen",   64'(bus.WP1_Wen), 64'(mon_e.wen));
                check("wp1_roben", 64'(bus.WP1_ROBEN), 64'(mon_e.roben));
                check("wp1_dr",    64'(bus.WP1_DRindex), 64'(mon_e.dr));
                check("wp1_data",  64'(bus.WP1_Data), 64'(mon_e.data));
                check("wp1_grant", 64'(bus.WP1_Grant), 64'(mon_e.grant));
            end
        end else begin
            check("wen_without_valid", 64'(bus.WP1_Wen), 64'd0);
            if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                check("missing_bundle", 64'd0, 64'd1);
                void'(sbq.pop_front());
            end
        end
    end

    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            int i = (rr + k) % NREQ;
            if (pend[i]) return i;
        end
        return -1;
    endfunction

    function automatic res_t mk(input logic wen, input int roben, input int dr, input logic [31:0] data);
        res_t r;
        r.wen   = wen;
        r.roben = RW'(roben);
        r.dr    = 5'(dr);
        r.data  = data;
        return r;
    endfunction

    task automatic set_rand(input int i);
        in_e[i].wen   = 1'($urandom);
        in_e[i].roben = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom_range(1, (1 << RW) - 1));
        in_e[i].dr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        in_e[i].data  = $urandom;
    endtask

    // One clock: drive at the falling edge, check ready, advance the model for the next rising edge.
    task automatic step(input logic [NREQ-1:0] v, input bit flush);
        logic [NREQ-1:0] rdy_exp;
        int   g;
        exp_t e;
        @(negedge clk);
        bus.req_valid      = v;
        bus.ROB_FLUSH_Flag = flush;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_wen[i]             = in_e[i].wen;
            bus.req_roben[i*RW +: RW]  = in_e[i].roben;
            bus.req_dr[i*5 +: 5]       = in_e[i].dr;
            bus.req_data[i*32 +: 32]   = in_e[i].data;
        end
        #1;
        g = pick();
        for (int i = 0; i < NREQ; i++) rdy_exp[i] = !flush && (!pend[i] || g == i);
        check("req_ready", 64'(bus.req_ready), 64'(rdy_exp));
        if (flush) begin
            for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
            rr = 0;
        end else begin
            if (g >= 0) begin
                e.wen   = pend_e[g].wen && (pend_e[g].dr != 5'd0);
                e.roben = pend_e[g].roben;
                e.dr    = pend_e[g].dr;
                e.data  = pend_e[g].data;
                e.grant = 3'(g);
                e.cyc   = cyc + 1;
                sbq.push_back(e);
                pend[g] = 1'b0;
`ifndef CDB_ARB_FIXED_PRIORITY_EN
                rr = (g + 1) % NREQ;
`endif
            end
            for (int i = 0; i < NREQ; i++) begin
                if (v[i] && rdy_exp[i] && in_e[i].roben != '0) begin
                    pend[i]   = 1'b1;
                    pend_e[i] = in_e[i];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.WP1_Valid), 64'd0);
        check({tag, "_wen"},   64'(bus.WP1_Wen), 64'd0);
        check({tag, "_roben"}, 64'(bus.WP1_ROBEN), 64'd0);
        check({tag, "_dr"},    64'(bus.WP1_DRindex), 64'd0);
        check({tag, "_data"},  64'(bus.WP1_Data), 64'd0);
        check({tag, "_grant"}, 64'(bus.WP1_Grant), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid      = '0;
        bus.ROB_FLUSH_Flag = 1'b0;
        bus.req_wen        = '0;
        bus.req_roben      = '0;
        bus.req_dr         = '0;
        bus.req_data       = '0;
        for (int i = 0; i < NREQ; i++) in_e[i] = mk(1'b0, 0, 0, 32'h0);

        // Reset state
        #13;
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(bus.req_ready), 64'({NREQ{1'b1}}));

        // Single uncontended result: visible two edges after req_valid, gone one edge later
        in_e[0] = mk(1'b1, 5, 3, 32'hDEAD_BEEF);
        step(3'b001, 1'b0);
        idle(3);

        // Three simultaneous results with ptr back at 0 (flush resets it)
        step(3'b000, 1'b1);
        for (int i = 0; i < NREQ; i++) in_e[i] = mk(1'b1, i + 1, i + 10, 32'h1000 + i);
        step(3'b111, 1'b0);
        idle(4);

        // Requester 0 streams while 1 and 2 are full
        for (int i = 0; i < NREQ; i++) in_e[i] = mk(1'b1, i + 4, i + 1, 32'h2000 + i);
        step(3'b111, 1'b0);
        for (int k = 0; k < 5; k++) begin
            in_e[0] = mk(1'b1, 8 + k, 2, 32'h3000 + k);
            step(3'b001, 1'b0);
        end
        idle(5);

        // Requester 1 back-to-back for four cycles
        for (int k = 0; k < 4; k++) begin
            in_e[1] = mk(1'b1, 2 + k, 7, 32'h4000 + k);
            step(3'b010, 1'b0);
        end
        idle(3);

        // dr=0 suppresses the write; roben=0 is dropped entirely
        in_e[0] = mk(1'b1, 7, 0, 32'h5555_0000);
        step(3'b001, 1'b0);
        idle(2);
        in_e[2] = mk(1'b1, 0, 9, 32'h6666_0000);
        step(3'b100, 1'b0);
        idle(3);

        // Flush with two buffers full while requester 2 presents
        in_e[0] = mk(1'b1, 3, 4, 32'h7000);
        in_e[1] = mk(1'b1, 6, 5, 32'h7001);
        step(3'b011, 1'b0);
        in_e[2] = mk(1'b1, 9, 6, 32'h7002);
        step(3'b100, 1'b1);
        idle(3);
        for (int i = 0; i < NREQ; i++) in_e[i] = mk(1'b1, i + 1, i + 1, 32'h7100 + i);
        step(3'b111, 1'b0);
        idle(4);

        // Randomized traffic with occasional flushes
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) set_rand(i);
            step(NREQ'($urandom), $urandom_range(0, 19) == 0);
        end
        idle(5);

        // Asynchronous reset between edges with all buffers full
        for (int i = 0; i < NREQ; i++) in_e[i] = mk(1'b1, i + 2, i + 3, 32'h8000 + i);
        step(3'b111, 1'b0);
        step(3'b000, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        check("ready_in_reset", 64'(bus.req_ready), 64'({NREQ{1'b1}}));
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        rr = 0;
        sbq.delete();
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_async_reset", 64'(bus.req_ready), 64'({NREQ{1'b1}}));
        idle(4);

        check("leftover_expected", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_writeback_arbiter.md
# cdb_writeback_arbiter

Arbitrates completed results from NREQ functional units (ALU, load/store, branch, …) onto the single register-file/CDB write port (WP1). Each requester gets a one-entry holding buffer. A round-robin arbiter issues at most one result per cycle as a registered WP1 bundle, and a ROB flush discards all pending results. Sits between the execution units and the register file / reservation-station CDB snoop.

## Interface
- NREQ, 3, number of requesters (2..8).
- RW, `ROB_SIZE_bits+1, ROB entry tag width (derived from the existing macro, not overridable).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ROB_FLUSH_Flag  in  1  squash all pending and in-flight results.
- req_valid  in  NREQ  requester i has a result.
- req_ready  out  NREQ  holding buffer i can accept (combinational).
- req_wen  in  NREQ  result writes a register.
- req_roben  in  NREQ*RW  ROB tag, packed, requester i at [i*RW +: RW].
- req_dr  in  NREQ*5  destination register index, packed.
- req_data  in  NREQ*32  result data, packed.
- WP1_Valid  out  1  CDB broadcast valid (ROB completion).
- WP1_Wen  out  1  register write enable; only ever 1 when WP1_Valid is 1.
- WP1_ROBEN  out  RW  ROB tag of the broadcast.
- WP1_DRindex  out  5  destination index.
- WP1_Data  out  32  result data.
- WP1_Grant  out  3  index of the requester that supplied the current bundle.

## Operation
- Holding buffer i stores {wen, roben, dr, data} and a full bit.
- Accept on a rising edge when req_valid[i] && req_ready[i].
- req_ready[i] = !full[i] || grant[i]. This gives back-to-back acceptance from one requester at one result per cycle.
- A request with roben == 0 is accepted and dropped: it never sets full and never appears on WP1.
- Arbitration considers only full buffers, never same-cycle inputs.
- Round-robin: a pointer ptr (0..NREQ-1) marks the highest-priority index. Search proceeds ptr, ptr+1, … modulo NREQ.
- After a grant to index g, ptr becomes (g+1) mod NREQ. With no grant, ptr is unchanged.
- Granted buffer: full clears on the edge, unless a new accept fills it on that same edge.
- Output register loads the granted entry:
  - WP1_Valid=1; WP1_Wen=wen && (dr != 0).
  - WP1_ROBEN, WP1_DRindex, WP1_Data copied from the entry; WP1_Grant=g.
- With no grant, WP1_Valid=0 and WP1_Wen=0. The other output fields hold their last value.
- Flush (ROB_FLUSH_Flag=1 on an edge):
  - All full bits clear and WP1_Valid/WP1_Wen go to 0.
  - Inputs presented that cycle are not captured; req_ready is forced to 0 while the flag is high.
  - ptr is reset to 0.

## Timing
- Reset: all full=0, ptr=0, WP1_Valid=0, WP1_Wen=0, WP1_ROBEN=0, WP1_DRindex=0, WP1_Data=0, WP1_Grant=0. req_ready is all ones once rst deasserts.
- Latency: a result accepted at edge N is earliest on WP1 after edge N+1 (two edges from req_valid to WP1), when uncontended.
- Throughput: one result per cycle total. With all NREQ buffers full and continuously refilled, each requester is granted once every NREQ cycles.
- Worst-case wait for a full buffer is NREQ-1 cycles.
- Flush takes priority over accept, grant and output update on the same edge.
- rst asserted mid-operation clears everything immediately, regardless of clk.
- No combinational path from req_* to WP1_*. Only req_ready depends combinationally on the grant and the flush.

## Configuration
- CDB_ARB_FIXED_PRIORITY_EN defined: the round-robin pointer is removed and priority is fixed, with index 0 highest. WP1_Grant is always the lowest full index. ptr logic is absent.
- Not defined: round-robin as described above (default build).

## Test plan
- Reset, then requester 0 sends {wen=1, roben=5, dr=3, data=0xDEADBEEF} at edge 1 → WP1_Valid=1, Wen=1, ROBEN=5, DRindex=3, Data=0xDEADBEEF, Grant=0 after edge 2; WP1_Valid=0 after edge 3.
- All three requesters send one result each on the same edge (roben 1, 2, 3) with ptr=0 → WP1 shows roben 1, 2, 3 on consecutive cycles and ptr ends at 0. Repeat the test with CDB_ARB_FIXED_PRIORITY_EN defined and requester 0 streaming continuously → requesters 1 and 2 starve while 0 streams.
- Requester 1 holds req_valid high for 4 cycles with no contention → req_ready[1] stays 1 and four WP1 bundles appear in consecutive cycles.
- Request with dr=0, wen=1, roben=7 → WP1_Valid=1, WP1_Wen=0. A request with roben=0 → no WP1_Valid pulse at all.
- Two buffers full, ROB_FLUSH_Flag high for one edge while requester 2 presents a result → no WP1_Valid afterward, requester 2's result is lost, and ptr=0.
- rst pulsed asynchronously between edges with all buffers full → all outputs return to the reset values immediately and req_ready becomes all ones.
